// File: rtl/serial_sub5_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub5_pkg;

  localparam int unsigned SUB_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Bit-counter width: clog2 of the operand width, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when a < b + bin.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow, purely combinational.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_sub5.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB5_SIGNED_OVF_EN.
module serial_sub5
  import serial_sub5_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB5_SIGNED_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  sub_state_t       state;
  sub_state_t       state_next;
  logic             load;
  logic             shift_en;
  logic             last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             cell_d;
  logic             cell_bout;

  // Single shared full-subtractor cell working on the current LSBs.
  full_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    last       = (cnt == CNT_W'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register with registered busy/done status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Operand shift registers, borrow flop, bit counter and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      a_sr       <= a;
      b_sr       <= b;
      br         <= borrow_in;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (shift_en) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      br   <= cell_bout;
      diff <= {cell_d, diff[WIDTH-1:1]};
      if (last) begin
        borrow_out <= cell_bout;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef SERIAL_SUB5_SIGNED_OVF_EN
  logic a_msb;
  logic b_msb;

  // Signed overflow: operand signs differ and result sign departs from a.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_msb    <= a[WIDTH-1];
      b_msb    <= b[WIDTH-1];
      overflow <= 1'b0;
    end else if (shift_en && last) begin
      overflow <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub5.sv
// Directed self-checking bench for serial_sub5 (WIDTH = 5).
module tb_serial_sub5;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] a;
  logic [4:0] b;
  logic       borrow_in;
  logic       busy;
  logic       done;
  logic [4:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB5_SIGNED_OVF_EN
  logic       overflow;
`endif

  int checks;
  int errors;
  int cyc;

  serial_sub5 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB5_SIGNED_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Wait (bounded) for IDLE, launch one operation, wait (bounded) for done.
  // Returns at the negedge where done is high.
  task automatic do_op(input logic [4:0] av, input logic [4:0] bv, input logic bi,
                       output int lat, output int busy_cnt, output logic ok);
    int w;
    ok = 1'b0; lat = 0; busy_cnt = 0;
    w = 0;
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    a = av; b = bv; borrow_in = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = i; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 5'd9; b = 5'd2; borrow_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (diff !== 5'd0) begin errors++; $display("FAIL reset_diff got %0d exp 0", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got %0b exp 0", borrow_out); end
`ifdef SERIAL_SUB5_SIGNED_OVF_EN
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
`endif
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %0b exp 0", busy); end
  endtask

  task automatic test_basic();
    int lat, bc; logic ok;
    do_op(5'd13, 5'd6, 1'b0, lat, bc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout got %0b exp 1", ok); end
    checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got %0d exp 5", lat); end
    checks++; if (bc != 6) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 6", bc); end
    checks++; if (diff !== 5'd7) begin errors++; $display("FAIL basic_diff got %0d exp 7", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL basic_borrow got %0b exp 0", borrow_out); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0b exp 0", busy); end
    checks++; if (diff !== 5'd7) begin errors++; $display("FAIL basic_diff_hold got %0d exp 7", diff); end
  endtask

  task automatic test_patterns();
    logic [4:0] ta [5] = '{5'd6, 5'd0, 5'd31, 5'd31, 5'd5};
    logic [4:0] tb [5] = '{5'd13, 5'd0, 5'd31, 5'd30, 5'd5};
    logic       ti [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] ed [5] = '{5'd25, 5'd31, 5'd0, 5'd0, 5'd31};
    logic       eb [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int lat, bc; logic ok;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], ti[i], lat, bc, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pat%0d_timeout got %0b exp 1", i, ok); end
      checks++; if (diff !== ed[i]) begin errors++; $display("FAIL pat%0d_diff got %0d exp %0d", i, diff, ed[i]); end
      checks++; if (borrow_out !== eb[i]) begin errors++; $display("FAIL pat%0d_borrow got %0b exp %0b", i, borrow_out, eb[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int n; int t0; int t1;
    n = 0; t0 = 0; t1 = 0;
    @(negedge clk);
    a = 5'd31; b = 5'd31; borrow_in = 1'b0; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n++;
        if (n == 1) begin
          t0 = cyc;
          checks++; if (diff !== 5'd0) begin errors++; $display("FAIL b2b_diff1 got %0d exp 0", diff); end
          checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL b2b_borrow1 got %0b exp 0", borrow_out); end
          a = 5'd10; b = 5'd3;
        end else begin
          t1 = cyc;
          checks++; if (diff !== 5'd7) begin errors++; $display("FAIL b2b_diff2 got %0d exp 7", diff); end
          checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL b2b_borrow2 got %0b exp 0", borrow_out); end
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checks++; if (n != 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", n); end
    checks++; if (t1 - t0 != 7) begin errors++; $display("FAIL b2b_spacing got %0d exp 7", t1 - t0); end
  endtask

  task automatic test_ignore_start();
    int k; logic seen; int extra;
    @(negedge clk);
    @(negedge clk);
    a = 5'd20; b = 5'd3; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 5'd1; b = 5'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ignore_timeout got %0b exp 1", seen); end
    checks++; if (diff !== 5'd17) begin errors++; $display("FAIL ignore_diff got %0d exp 17", diff); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_no_second_op got %0d exp 0", extra); end
  endtask

  task automatic test_abort();
    int dn; int bz; int lat; int bc; logic ok;
    @(negedge clk);
    a = 5'd20; b = 5'd3; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 5'd1; b = 5'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b exp 0", busy); end
    checks++; if (diff !== 5'd0) begin errors++; $display("FAIL abort_diff got %0d exp 0", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL abort_borrow got %0b exp 0", borrow_out); end
    dn = 0; bz = 0;
    if (done) dn++;
    repeat (10) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", dn); end
    checks++; if (bz != 0) begin errors++; $display("FAIL abort_stays_idle got %0d exp 0", bz); end
    do_op(5'd20, 5'd3, 1'b0, lat, bc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL restart_timeout got %0b exp 1", ok); end
    checks++; if (diff !== 5'd17) begin errors++; $display("FAIL restart_diff got %0d exp 17", diff); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL restart_borrow got %0b exp 0", borrow_out); end
  endtask

`ifdef SERIAL_SUB5_SIGNED_OVF_EN
  task automatic test_overflow();
    int lat, bc; logic ok;
    do_op(5'd16, 5'd1, 1'b0, lat, bc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf1_timeout got %0b exp 1", ok); end
    checks++; if (diff !== 5'd15) begin errors++; $display("FAIL ovf1_diff got %0d exp 15", diff); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf1_flag got %0b exp 1", overflow); end
    checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL ovf1_borrow got %0b exp 0", borrow_out); end
    do_op(5'd5, 5'd3, 1'b0, lat, bc, ok);
    checks++; if (diff !== 5'd2) begin errors++; $display("FAIL ovf2_diff got %0d exp 2", diff); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf2_flag got %0b exp 0", overflow); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_ignore_start();
    test_abort();
`ifdef SERIAL_SUB5_SIGNED_OVF_EN
    test_overflow();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
